sopc_mem_arbiter: RTL and testbench

- Shares the single-port program/data RAM of openmips_min_sopc between the CPU instruction-fetch port and the CPU data-access port.
- Sits between the core and the RAM. Arbitrates round-robin, sequences each RAM access with a fixed latency, and returns a one-cycle ack with read data.
- Drives a stall request to the pipeline ctrl block while any requester is waiting.

---
 rtl/sopc_mem_arbiter_pkg.sv | 29 ++
 rtl/sopc_mem_arbiter_if.sv | 52 +++++
 rtl/sopc_mem_arbiter_rr_arbiter2.sv | 44 ++++
 rtl/sopc_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_sopc_mem_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sopc_mem_arbiter_pkg.sv
// Shared types and constants for the openmips_min_sopc RAM arbiter.
// Imported by the interface, the round-robin picker and the arbiter top.
package sopc_mem_arbiter_pkg;

   localparam int unsigned ARB_ADDR_W = 32;
   localparam int unsigned ARB_DATA_W = 32;
   localparam int unsigned SEL_W      = 4;
   localparam int unsigned CNT_W      = 3;

   localparam logic CHIP_ENABLE   = 1'b1;
   localparam logic CHIP_DISABLE  = 1'b0;
   localparam logic WRITE_DISABLE = 1'b0;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_RESP   = 2'd2
   } arb_state_e;

   typedef enum logic {
      ARB_M_IF  = 1'b0,
      ARB_M_MEM = 1'b1
   } arb_master_e;

   function automatic arb_master_e other_master(input arb_master_e m);
      return (m == ARB_M_IF) ? ARB_M_MEM : ARB_M_IF;
   endfunction

endpackage

// File: rtl/sopc_mem_arbiter_if.sv
// Core-side (fetch + data) and RAM-side signals of the arbiter.
// Signal directions are named from the arbiter's point of view.
interface sopc_mem_arbiter_if
   import sopc_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ARB_ADDR_W,
   parameter int unsigned DATA_W = ARB_DATA_W
) ();

   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_ack_o;
   logic [DATA_W-1:0] if_data_o;

   logic              mem_req_i;
   logic              mem_we_i;
   logic [ADDR_W-1:0] mem_addr_i;
   logic [SEL_W-1:0]  mem_sel_i;
   logic [DATA_W-1:0] mem_data_i;
   logic              mem_ack_o;
   logic [DATA_W-1:0] mem_data_o;

   logic              ram_ce_o;
   logic              ram_we_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic [SEL_W-1:0]  ram_sel_o;
   logic [DATA_W-1:0] ram_data_o;
   logic [DATA_W-1:0] ram_data_i;

   logic              stall_req_o;

   modport slave (
      input  if_req_i, if_addr_i,
      output if_ack_o, if_data_o,
      input  mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
      output mem_ack_o, mem_data_o,
      output ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
      input  ram_data_i,
      output stall_req_o
   );

   modport master (
      output if_req_i, if_addr_i,
      input  if_ack_o, if_data_o,
      output mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
      input  mem_ack_o, mem_data_o,
      input  ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
      output ram_data_i,
      input  stall_req_o
   );

endinterface

// File: rtl/sopc_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: combinational grant, registered preference pointer.
// The pointer moves to the master not just served whenever upd_i strobes.
module rr_arbiter2
   import sopc_mem_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_i,
   input  logic        mem_req_i,
   input  logic        upd_i,
   input  arb_master_e upd_id_i,
   output logic        gnt_valid_c_o,
   output arb_master_e gnt_id_c_o
);

   arb_master_e ptr_q, ptr_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= ARB_M_MEM;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (upd_i) begin
         ptr_d = other_master(upd_id_i);
      end
   end

   // A lone requester wins outright; the pointer only breaks ties.
   always_comb begin
      gnt_valid_c_o = if_req_i | mem_req_i;
      gnt_id_c_o    = ptr_q;
      if (if_req_i && !mem_req_i) begin
         gnt_id_c_o = ARB_M_IF;
      end else if (mem_req_i && !if_req_i) begin
         gnt_id_c_o = ARB_M_MEM;
      end
   end

endmodule

// File: rtl/sopc_mem_arbiter.sv
// Shares the single-port SOPC RAM between CPU fetch and data ports:
// round-robin grant, fixed-latency access, one-cycle ack with read data.
module sopc_mem_arbiter
   import sopc_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W  = ARB_ADDR_W,
   parameter int unsigned DATA_W  = ARB_DATA_W,
   parameter int unsigned RAM_LAT = 1
) (
   input logic               clk,
   input logic               rst,
   sopc_mem_arbiter_if.slave bus
);

   arb_state_e        state_q, state_d;
   arb_master_e       gnt_q, gnt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ce_q, ce_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              if_ack_q, if_ack_d;
   logic              mem_ack_q, mem_ack_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

   logic              rr_upd;
   logic              pick_valid;
   arb_master_e       pick_id;

   rr_arbiter2 u_rr (
      .clk           (clk),
      .rst           (rst),
      .if_req_i      (bus.if_req_i),
      .mem_req_i     (bus.mem_req_i),
      .upd_i         (rr_upd),
      .upd_id_i      (gnt_q),
      .gnt_valid_c_o (pick_valid),
      .gnt_id_c_o    (pick_id)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ARB_IDLE;
         gnt_q       <= ARB_M_IF;
         cnt_q       <= '0;
         ce_q        <= CHIP_DISABLE;
         we_q        <= WRITE_DISABLE;
         addr_q      <= '0;
         sel_q       <= '0;
         wdata_q     <= '0;
         if_ack_q    <= 1'b0;
         mem_ack_q   <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         cnt_q       <= cnt_d;
         ce_q        <= ce_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         sel_q       <= sel_d;
         wdata_q     <= wdata_d;
         if_ack_q    <= if_ack_d;
         mem_ack_q   <= mem_ack_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      cnt_d       = cnt_q;
      ce_d        = ce_q;
      we_d        = we_q;
      addr_d      = addr_q;
      sel_d       = sel_q;
      wdata_d     = wdata_q;
      if_ack_d    = 1'b0;
      mem_ack_d   = 1'b0;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      rr_upd      = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               gnt_d   = pick_id;
               ce_d    = CHIP_ENABLE;
               cnt_d   = CNT_W'(RAM_LAT - 1);
               state_d = ARB_ACCESS;
               if (pick_id == ARB_M_IF) begin
                  we_d   = WRITE_DISABLE;
                  addr_d = bus.if_addr_i;
                  sel_d  = {SEL_W{1'b1}};
               end else begin
                  we_d    = bus.mem_we_i;
                  addr_d  = bus.mem_addr_i;
                  sel_d   = bus.mem_sel_i;
                  wdata_d = bus.mem_data_i;
               end
            end
         end

         // Completes even if the requester has since dropped its request.
         ARB_ACCESS: begin
            if (cnt_q == '0) begin
               ce_d    = CHIP_DISABLE;
               we_d    = WRITE_DISABLE;
               rr_upd  = 1'b1;
               state_d = ARB_RESP;
               if (gnt_q == ARB_M_IF) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = bus.ram_data_i;
               end else begin
                  mem_ack_d = 1'b1;
                  if (!we_q) begin
                     mem_rdata_d = bus.ram_data_i;
                  end
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         // Bubble cycle: ack is visible before anyone is re-arbitrated.
         ARB_RESP: begin
            state_d = ARB_IDLE;
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   assign bus.ram_ce_o   = ce_q;
   assign bus.ram_we_o   = we_q;
   assign bus.ram_addr_o = addr_q;
   assign bus.ram_sel_o  = sel_q;
   assign bus.ram_data_o = wdata_q;
   assign bus.if_ack_o   = if_ack_q;
   assign bus.if_data_o  = if_rdata_q;
   assign bus.mem_ack_o  = mem_ack_q;
   assign bus.mem_data_o = mem_rdata_q;

   assign bus.stall_req_o = (bus.if_req_i & ~if_ack_q) | (bus.mem_req_i & ~mem_ack_q);

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Directed bench for sopc_mem_arbiter: one DUT at RAM_LAT=1, one at RAM_LAT=3.
module tb_sopc_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] w20;

   always #5 clk = ~clk;

   sopc_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
   sopc_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

   sopc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1)) u_dut1 (
      .clk (clk), .rst (rst), .bus (b1.slave)
   );
   sopc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(3)) u_dut3 (
      .clk (clk), .rst (rst), .bus (b3.slave)
   );

   // RAM models: fixed words at 0x10, a writable word at 0x20, address-derived elsewhere
   assign b1.ram_data_i = (b1.ram_addr_o == 32'h10) ? 32'h3401_1100 :
                          (b1.ram_addr_o == 32'h20) ? w20 : (b1.ram_addr_o ^ 32'h5A5A_0000);
   assign b3.ram_data_i = b3.ram_addr_o ^ 32'hC3C3_0000;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         w20 <= 32'h1122_3344;
      end else if (b1.ram_ce_o && b1.ram_we_o && b1.ram_addr_o == 32'h20) begin
         for (int i = 0; i < 4; i++) begin
            if (b1.ram_sel_o[i]) w20[8*i +: 8] <= b1.ram_data_o[8*i +: 8];
         end
      end
   end

   task automatic idle_inputs();
      b1.if_req_i = 0; b1.if_addr_i = '0; b1.mem_req_i = 0; b1.mem_we_i = 0;
      b1.mem_addr_i = '0; b1.mem_sel_i = '0; b1.mem_data_i = '0;
      b3.if_req_i = 0; b3.if_addr_i = '0; b3.mem_req_i = 0; b3.mem_we_i = 0;
      b3.mem_addr_i = '0; b3.mem_sel_i = '0; b3.mem_data_i = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      b1.if_req_i = 1; b1.mem_req_i = 1; b3.if_req_i = 1; b3.mem_req_i = 1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_checks++;
         if ({b1.ram_ce_o, b3.ram_ce_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ce cycle %0d: got %b%b expected 00", c, b1.ram_ce_o, b3.ram_ce_o);
         end
      end
      n_checks++;
      if ({b1.ram_we_o, b1.ram_addr_o, b1.ram_sel_o, b1.ram_data_o, b1.if_ack_o, b1.if_data_o,
           b1.mem_ack_o, b1.mem_data_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outs_lat1: got ack %b/%b data %h/%h expected all 0",
                  b1.if_ack_o, b1.mem_ack_o, b1.if_data_o, b1.mem_data_o);
      end
      n_checks++;
      if ({b3.ram_we_o, b3.ram_addr_o, b3.ram_sel_o, b3.ram_data_o, b3.if_ack_o, b3.if_data_o,
           b3.mem_ack_o, b3.mem_data_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outs_lat3: got ack %b/%b data %h/%h expected all 0",
                  b3.if_ack_o, b3.mem_ack_o, b3.if_data_o, b3.mem_data_o);
      end
      @(posedge clk); #1;
      idle_inputs();
      rst = 1'b1;
   endtask

   task automatic test_fetch();
      @(posedge clk); #1;
      b1.if_req_i = 1; b1.if_addr_i = 32'h10;
      @(negedge clk);
      n_checks++;
      if ({b1.stall_req_o, b1.ram_ce_o} !== 2'b10) begin
         n_fail++;
         $display("FAIL fetch_c0 stall/ce: got %b%b expected 10", b1.stall_req_o, b1.ram_ce_o);
      end
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({b1.ram_ce_o, b1.ram_we_o, b1.ram_sel_o, b1.ram_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h10}) begin
         n_fail++;
         $display("FAIL fetch_c1 ram: got ce %b we %b sel %h addr %h expected 1 0 f 00000010",
                  b1.ram_ce_o, b1.ram_we_o, b1.ram_sel_o, b1.ram_addr_o);
      end
      n_checks++;
      if ({b1.stall_req_o, b1.if_ack_o} !== 2'b10) begin
         n_fail++;
         $display("FAIL fetch_c1 stall/ack: got %b%b expected 10", b1.stall_req_o, b1.if_ack_o);
      end
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({b1.if_ack_o, b1.ram_ce_o, b1.stall_req_o} !== 3'b100) begin
         n_fail++;
         $display("FAIL fetch_c2 ack/ce/stall: got %b%b%b expected 100",
                  b1.if_ack_o, b1.ram_ce_o, b1.stall_req_o);
      end
      n_checks++;
      if (b1.if_data_o !== 32'h3401_1100) begin
         n_fail++;
         $display("FAIL fetch_data: got %h expected 34011100", b1.if_data_o);
      end
      @(posedge clk); #1;
      b1.if_req_i = 0;
      @(negedge clk);
      n_checks++;
      if ({b1.if_ack_o, b1.stall_req_o, b1.if_data_o} !== {2'b00, 32'h3401_1100}) begin
         n_fail++;
         $display("FAIL fetch_c3 hold: got ack %b stall %b data %h expected 0 0 34011100",
                  b1.if_ack_o, b1.stall_req_o, b1.if_data_o);
      end
   endtask

   task automatic test_mem_read(input logic [31:0] exp_d, input string tag);
      @(posedge clk); #1;
      b1.mem_req_i = 1; b1.mem_we_i = 0; b1.mem_addr_i = 32'h20; b1.mem_sel_i = 4'hF;
      @(posedge clk); @(posedge clk); @(negedge clk);
      n_checks++;
      if ({b1.mem_ack_o, b1.mem_data_o, b1.if_data_o} !== {1'b1, exp_d, 32'h3401_1100}) begin
         n_fail++;
         $display("FAIL %s: got ack %b data %h ifdata %h expected 1 %h 34011100",
                  tag, b1.mem_ack_o, b1.mem_data_o, b1.if_data_o, exp_d);
      end
      @(posedge clk); #1;
      b1.mem_req_i = 0;
   endtask

   task automatic test_write();
      @(posedge clk); #1;
      b1.mem_req_i = 1; b1.mem_we_i = 1; b1.mem_addr_i = 32'h20;
      b1.mem_sel_i = 4'b0011; b1.mem_data_i = 32'hDEAD_BEEF;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({b1.ram_ce_o, b1.ram_we_o, b1.ram_sel_o, b1.ram_addr_o, b1.ram_data_o} !==
          {1'b1, 1'b1, 4'b0011, 32'h20, 32'hDEAD_BEEF}) begin
         n_fail++;
         $display("FAIL write_c1 ram: got ce %b we %b sel %h addr %h data %h expected 1 1 3 00000020 deadbeef",
                  b1.ram_ce_o, b1.ram_we_o, b1.ram_sel_o, b1.ram_addr_o, b1.ram_data_o);
      end
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({b1.mem_ack_o, b1.ram_ce_o, b1.ram_we_o, b1.mem_data_o} !== {3'b100, 32'h1122_3344}) begin
         n_fail++;
         $display("FAIL write_c2 ack: got ack %b ce %b we %b data %h expected 1 0 0 11223344",
                  b1.mem_ack_o, b1.ram_ce_o, b1.ram_we_o, b1.mem_data_o);
      end
      @(posedge clk); #1;
      b1.mem_req_i = 0; b1.mem_we_i = 0;
      @(negedge clk);
      n_checks++;
      if (b1.mem_ack_o !== 1'b0) begin
         n_fail++;
         $display("FAIL write_ack_width: got %b expected 0", b1.mem_ack_o);
      end
   endtask

   task automatic test_contention();
      int   g[4];
      int   exp_g[4] = '{1, 0, 1, 0};
      int   ng = 0, both_err = 0, long_err = 0, data_err = 0, ia = 0, ma = 0;
      logic pce = 0, pia = 0, pma = 0;
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      b1.if_req_i = 1; b1.if_addr_i = 32'h10;
      b1.mem_req_i = 1; b1.mem_we_i = 0; b1.mem_addr_i = 32'h20; b1.mem_sel_i = 4'hF;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(posedge clk);
         @(negedge clk);
         if (b1.ram_ce_o && !pce && ng < 4) begin
            g[ng] = (b1.ram_addr_o == 32'h20) ? 1 : 0;
            ng++;
         end
         if (b1.if_ack_o && b1.mem_ack_o) both_err++;
         if ((b1.if_ack_o && pia) || (b1.mem_ack_o && pma)) long_err++;
         if (b1.if_ack_o) begin ia++; if (b1.if_data_o !== 32'h3401_1100) data_err++; end
         if (b1.mem_ack_o) begin ma++; if (b1.mem_data_o !== 32'h1122_3344) data_err++; end
         pce = b1.ram_ce_o; pia = b1.if_ack_o; pma = b1.mem_ack_o;
      end
      @(posedge clk); #1;
      b1.if_req_i = 0; b1.mem_req_i = 0;
      n_checks++;
      if (ng !== 4) begin
         n_fail++;
         $display("FAIL contention_grants: got %0d expected 4", ng);
      end
      for (int i = 0; i < 4 && i < ng; i++) begin
         n_checks++;
         if (g[i] !== exp_g[i]) begin
            n_fail++;
            $display("FAIL contention_order[%0d]: got %0d expected %0d (1=MEM 0=IF)", i, g[i], exp_g[i]);
         end
      end
      n_checks++;
      if ({both_err, long_err, data_err} !== {32'd0, 32'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL contention_acks: got both %0d long %0d data %0d expected 0 0 0",
                  both_err, long_err, data_err);
      end
      n_checks++;
      if ({ia, ma} !== {32'd2, 32'd2}) begin
         n_fail++;
         $display("FAIL contention_counts: got if %0d mem %0d expected 2 2", ia, ma);
      end
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (b1.ram_ce_o !== 1'b0) begin
         n_fail++;
         $display("FAIL contention_idle: got ce %b expected 0", b1.ram_ce_o);
      end
   endtask

   task automatic test_latency();
      logic [5:0] cev, ackv;
      logic [31:0] d;
      int rise[2], acks[2];
      int nr = 0, na = 0;
      logic pce = 0;
      @(posedge clk); #1;
      b3.if_req_i = 1; b3.if_addr_i = 32'h100;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(posedge clk);
         if (c == 5) begin #1; b3.if_req_i = 0; end
         @(negedge clk);
         cev[c] = b3.ram_ce_o; ackv[c] = b3.if_ack_o;
         if (c == 4) d = b3.if_data_o;
      end
      n_checks++;
      if ({cev, ackv} !== {6'b001110, 6'b010000}) begin
         n_fail++;
         $display("FAIL lat3_timing: got ce %b ack %b expected 001110 010000", cev, ackv);
      end
      n_checks++;
      if (d !== 32'hC3C3_0100) begin
         n_fail++;
         $display("FAIL lat3_data: got %h expected c3c30100", d);
      end
      @(posedge clk); #1;
      b3.mem_req_i = 1; b3.mem_we_i = 0; b3.mem_addr_i = 32'h200; b3.mem_sel_i = 4'hF;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(posedge clk);
         @(negedge clk);
         if (b3.ram_ce_o && !pce && nr < 2) begin rise[nr] = c; nr++; end
         if (b3.mem_ack_o && na < 2) begin acks[na] = c; na++; end
         pce = b3.ram_ce_o;
      end
      @(posedge clk); #1;
      b3.mem_req_i = 0;
      n_checks++;
      if (nr != 2 || na != 2 || rise[1] - rise[0] != 5 || acks[0] != 4 || acks[1] != 9) begin
         n_fail++;
         $display("FAIL lat3_b2b: got %0d rises %0d acks (first rise %0d) expected spacing 5 acks at 4 9",
                  nr, na, (nr > 0) ? rise[0] : -1);
      end
      n_checks++;
      if (b3.mem_data_o !== 32'hC3C3_0200) begin
         n_fail++;
         $display("FAIL lat3_b2b_data: got %h expected c3c30200", b3.mem_data_o);
      end
   endtask

   task automatic test_abandon();
      @(posedge clk); #1;
      b1.if_req_i = 1; b1.if_addr_i = 32'h10;
      b1.mem_req_i = 1; b1.mem_we_i = 0; b1.mem_addr_i = 32'h20; b1.mem_sel_i = 4'hF;
      @(posedge clk); #1;
      b1.mem_req_i = 0;
      @(negedge clk);
      n_checks++;
      if ({b1.ram_ce_o, b1.ram_addr_o} !== {1'b1, 32'h20}) begin
         n_fail++;
         $display("FAIL abandon_grant: got ce %b addr %h expected 1 00000020", b1.ram_ce_o, b1.ram_addr_o);
      end
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({b1.mem_ack_o, b1.if_ack_o, b1.mem_data_o} !== {2'b10, 32'h1122_3344}) begin
         n_fail++;
         $display("FAIL abandon_ack: got mem %b if %b data %h expected 1 0 11223344",
                  b1.mem_ack_o, b1.if_ack_o, b1.mem_data_o);
      end
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({b1.ram_ce_o, b1.ram_we_o, b1.ram_addr_o} !== {2'b10, 32'h10}) begin
         n_fail++;
         $display("FAIL abandon_next_if: got ce %b we %b addr %h expected 1 0 00000010",
                  b1.ram_ce_o, b1.ram_we_o, b1.ram_addr_o);
      end
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({b1.if_ack_o, b1.mem_ack_o} !== 2'b10) begin
         n_fail++;
         $display("FAIL abandon_if_ack: got if %b mem %b expected 1 0", b1.if_ack_o, b1.mem_ack_o);
      end
      @(posedge clk); #1;
      b1.if_req_i = 0;
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      @(posedge clk); #1;
      b3.mem_req_i = 1; b3.mem_we_i = 1; b3.mem_addr_i = 32'h300;
      b3.mem_sel_i = 4'hF; b3.mem_data_i = 32'hCAFE_F00D;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({b3.ram_ce_o, b3.ram_we_o} !== 2'b11) begin
         n_fail++;
         $display("FAIL rstmid_pre: got ce %b we %b expected 1 1", b3.ram_ce_o, b3.ram_we_o);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({b3.ram_ce_o, b3.ram_we_o, b3.ram_addr_o} !== {2'b00, 32'h0}) begin
         n_fail++;
         $display("FAIL rstmid_async: got ce %b we %b addr %h expected 0 0 00000000",
                  b3.ram_ce_o, b3.ram_we_o, b3.ram_addr_o);
      end
      idle_inputs();
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (b3.mem_ack_o || b3.if_ack_o || b3.ram_ce_o) bad++;
         @(posedge clk);
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL rstmid_no_ack: got %0d active cycles expected 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_mem_read(32'h1122_3344, "mem_read");
      test_write();
      test_mem_read(32'h1122_BEEF, "write_readback");
      test_contention();
      test_latency();
      test_abandon();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
